// File: rtl/simple_multicycle_ctrl_pkg.sv
// rtl/simple_multicycle_ctrl_pkg.sv - shared encodings for the multicycle controller
package simple_multicycle_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_INIT      = 4'd0,
        ST_FETCH     = 4'd1,
        ST_DECODE    = 4'd2,
        ST_MEM_ADDR  = 4'd3,
        ST_MEM_READ  = 4'd4,
        ST_MEM_WB    = 4'd5,
        ST_MEM_WRITE = 4'd6,
        ST_R_EXEC    = 4'd7,
        ST_R_WB      = 4'd8,
        ST_I_EXEC    = 4'd9,
        ST_I_WB      = 4'd10,
        ST_BRANCH    = 4'd11,
        ST_JUMP      = 4'd12
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    typedef enum logic [1:0] {
        ALU_ADD   = 2'b00,
        ALU_SUB   = 2'b01,
        ALU_FUNCT = 2'b10,
        ALU_SLT   = 2'b11
    } alu_op_e;

    typedef enum logic [1:0] {
        SRCB_REG     = 2'b00,
        SRCB_FOUR    = 2'b01,
        SRCB_IMM     = 2'b10,
        SRCB_IMM_SH2 = 2'b11
    } alu_src_b_e;

    typedef enum logic [1:0] {
        PCSRC_ALU    = 2'b00,
        PCSRC_ALUOUT = 2'b01,
        PCSRC_JUMP   = 2'b10,
        PCSRC_RSVD   = 2'b11
    } pc_source_e;

endpackage

// File: rtl/simple_multicycle_ctrl_if.sv
// rtl/simple_multicycle_ctrl_if.sv - controller/datapath signal bundle
// master: controller side (drives control strobes, status)
// slave:  datapath side (drives opcode and memory ready)
interface simple_multicycle_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [5:0]       instr_op;
    logic             mem_ready;
    logic             pc_write;
    logic             pc_write_cond;
    logic [1:0]       pc_source;
    logic             i_or_d;
    logic             mem_read;
    logic             mem_write;
    logic             ir_write;
    logic             reg_dst;
    logic             mem_to_reg;
    logic             reg_write;
    logic             alu_src_a;
    logic [1:0]       alu_src_b;
    logic [1:0]       alu_op;
    logic             illegal;
    logic [CNT_W-1:0] instr_count;

    modport master (
        input  instr_op, mem_ready,
        output pc_write, pc_write_cond, pc_source, i_or_d, mem_read, mem_write,
               ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b,
               alu_op, illegal, instr_count
    );

    modport slave (
        output instr_op, mem_ready,
        input  pc_write, pc_write_cond, pc_source, i_or_d, mem_read, mem_write,
               ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b,
               alu_op, illegal, instr_count
    );
endinterface

// File: rtl/simple_multicycle_ctrl.sv
// rtl/simple_multicycle_ctrl.sv - multicycle CPU control FSM with retire counter
// Ports:
//   clk_i, rst_i (async, active-low)
//   instr_op_i, mem_ready_i           : opcode from IR, memory handshake
//   pc_write_o, pc_write_cond_o, pc_source_o, i_or_d_o, mem_read_o,
//   mem_write_o, ir_write_o, reg_dst_o, mem_to_reg_o, reg_write_o,
//   alu_src_a_o, alu_src_b_o, alu_op_o : datapath controls
//   illegal_o (sticky), instr_count_o (retired instructions, wraps)
module simple_multicycle_ctrl
    import simple_multicycle_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [5:0]       instr_op_i,
    input  logic             mem_ready_i,
    output logic             pc_write_o,
    output logic             pc_write_cond_o,
    output logic [1:0]       pc_source_o,
    output logic             i_or_d_o,
    output logic             mem_read_o,
    output logic             mem_write_o,
    output logic             ir_write_o,
    output logic             reg_dst_o,
    output logic             mem_to_reg_o,
    output logic             reg_write_o,
    output logic             alu_src_a_o,
    output logic [1:0]       alu_src_b_o,
    output logic [1:0]       alu_op_o,
    output logic             illegal_o,
    output logic [CNT_W-1:0] instr_count_o
);

    state_e           state_q, state_d;
    logic             illegal_q, illegal_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             retire;

    // Next-state, retire and sticky-flag logic.
    always_comb begin
        state_d   = state_q;
        illegal_d = illegal_q;
        retire    = 1'b0;
        case (state_q)
            ST_INIT:  state_d = ST_FETCH;
            ST_FETCH: if (mem_ready_i) state_d = ST_DECODE;
            ST_DECODE: begin
                case (instr_op_i)
                    OP_RTYPE:        state_d = ST_R_EXEC;
                    OP_ADDI, OP_SLTI: state_d = ST_I_EXEC;
                    OP_LW, OP_SW:    state_d = ST_MEM_ADDR;
                    OP_BEQ:          state_d = ST_BRANCH;
                    OP_J:            state_d = ST_JUMP;
                    default: begin
                        // Unknown opcode: abandon the instruction without retiring it.
                        state_d   = ST_FETCH;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            ST_MEM_ADDR: begin
                if (instr_op_i == OP_LW)      state_d = ST_MEM_READ;
                else if (instr_op_i == OP_SW) state_d = ST_MEM_WRITE;
                else                          state_d = ST_FETCH;
            end
            ST_MEM_READ: if (mem_ready_i) state_d = ST_MEM_WB;
            ST_MEM_WRITE: begin
                if (mem_ready_i) begin
                    state_d = ST_FETCH;
                    retire  = 1'b1;
                end
            end
            ST_R_EXEC: state_d = ST_R_WB;
            ST_I_EXEC: state_d = ST_I_WB;
            ST_MEM_WB, ST_R_WB, ST_I_WB, ST_BRANCH, ST_JUMP: begin
                state_d = ST_FETCH;
                retire  = 1'b1;
            end
            default: state_d = ST_INIT;
        endcase
        cnt_d = retire ? cnt_q + CNT_W'(1) : cnt_q;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q   <= ST_INIT;
            illegal_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
            cnt_q     <= cnt_d;
        end
    end

    // Output decode from the state register; because state resets
    // asynchronously, every strobe drops the moment reset asserts.
    always_comb begin
        pc_write_o      = 1'b0;
        pc_write_cond_o = 1'b0;
        pc_source_o     = PCSRC_ALU;
        i_or_d_o        = 1'b0;
        mem_read_o      = 1'b0;
        mem_write_o     = 1'b0;
        ir_write_o      = 1'b0;
        reg_dst_o       = 1'b0;
        mem_to_reg_o    = 1'b0;
        reg_write_o     = 1'b0;
        alu_src_a_o     = 1'b0;
        alu_src_b_o     = SRCB_REG;
        alu_op_o        = ALU_ADD;
        case (state_q)
            ST_FETCH: begin
                mem_read_o  = 1'b1;
                alu_src_b_o = SRCB_FOUR;
                // IR and PC only load on the cycle the fetch completes.
                ir_write_o  = mem_ready_i;
                pc_write_o  = mem_ready_i;
            end
            ST_DECODE: alu_src_b_o = SRCB_IMM_SH2;
            ST_MEM_ADDR: begin
                alu_src_a_o = 1'b1;
                alu_src_b_o = SRCB_IMM;
            end
            ST_MEM_READ: begin
                mem_read_o = 1'b1;
                i_or_d_o   = 1'b1;
            end
            ST_MEM_WRITE: begin
                mem_write_o = 1'b1;
                i_or_d_o    = 1'b1;
            end
            ST_MEM_WB: begin
                reg_write_o  = 1'b1;
                mem_to_reg_o = 1'b1;
            end
            ST_R_EXEC: begin
                alu_src_a_o = 1'b1;
                alu_op_o    = ALU_FUNCT;
            end
            ST_R_WB: begin
                reg_write_o = 1'b1;
                reg_dst_o   = 1'b1;
            end
            ST_I_EXEC: begin
                alu_src_a_o = 1'b1;
                alu_src_b_o = SRCB_IMM;
                alu_op_o    = (instr_op_i == OP_SLTI) ? ALU_SLT : ALU_ADD;
            end
            ST_I_WB: reg_write_o = 1'b1;
            ST_BRANCH: begin
                alu_src_a_o     = 1'b1;
                alu_op_o        = ALU_SUB;
                pc_write_cond_o = 1'b1;
                pc_source_o     = PCSRC_ALUOUT;
            end
            ST_JUMP: begin
                pc_write_o  = 1'b1;
                pc_source_o = PCSRC_JUMP;
            end
            default: ;
        endcase
    end

    assign illegal_o     = illegal_q;
    assign instr_count_o = cnt_q;

endmodule

// File: doc/simple_multicycle_ctrl.md
SIMPLE_MULTICYCLE_CTRL -- requirements
Module: simple_multicycle_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 32, width of the retired-instruction counter.
REQ-002 SHALL have port clk_i  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port rst_i  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port instr_op_i  input  6  opcode field of the instruction register.
REQ-005 SHALL have port mem_ready_i  input  1  memory access complete this cycle.
REQ-006 SHALL have port pc_write_o  output  1  unconditional PC load.
REQ-007 SHALL have port pc_write_cond_o  output  1  PC load qualified by ALU zero (beq).
REQ-008 SHALL have port pc_source_o  output  2  00 ALU result, 01 ALUOut register, 10 jump target.
REQ-009 SHALL have port i_or_d_o  output  1  memory address select: 0 PC, 1 ALUOut.
REQ-010 SHALL have ports mem_read_o, mem_write_o  output  1 each  memory strobes.
REQ-011 SHALL have port ir_write_o  output  1  instruction register load.
REQ-012 SHALL have ports reg_dst_o, mem_to_reg_o, reg_write_o  output  1 each  register-file write controls.
REQ-013 SHALL have ports alu_src_a_o (1), alu_src_b_o (2: 00 reg, 01 const 4, 10 sign-ext, 11 sign-ext<<2)  output.
REQ-014 SHALL have port alu_op_o  output  2  00 add, 01 sub, 10 use funct, 11 set-less-than.
REQ-015 SHALL have ports illegal_o (1, sticky flag) and instr_count_o (CNT_W, retired count)  output.

Function
REQ-016 SHALL implement states INIT, FETCH, DECODE, MEM_ADDR, MEM_READ, MEM_WB, MEM_WRITE, R_EXEC, R_WB, I_EXEC, I_WB, BRANCH, JUMP.
REQ-017 INIT: all control outputs 0; always -> FETCH next cycle.
REQ-018 FETCH: mem_read_o=1, i_or_d_o=0, alu_src_a_o=0, alu_src_b_o=01, alu_op_o=00, pc_source_o=00; ir_write_o and pc_write_o equal mem_ready_i; stay while mem_ready_i=0, -> DECODE when 1.
REQ-019 DECODE: alu_src_a_o=0, alu_src_b_o=11, alu_op_o=00; next by opcode: 0x00 R_EXEC, 0x08/0x0A I_EXEC, 0x23/0x2B MEM_ADDR, 0x04 BRANCH, 0x02 JUMP, other -> FETCH with illegal_o set.
REQ-020 MEM_ADDR: alu_src_a_o=1, alu_src_b_o=10, alu_op_o=00; opcode 0x23 -> MEM_READ, 0x2B -> MEM_WRITE.
REQ-021 MEM_READ: mem_read_o=1, i_or_d_o=1; hold until mem_ready_i=1, then -> MEM_WB.
REQ-022 MEM_WRITE: mem_write_o=1, i_or_d_o=1; hold until mem_ready_i=1, then -> FETCH (retire).
REQ-023 MEM_WB: reg_write_o=1, mem_to_reg_o=1, reg_dst_o=0; -> FETCH (retire).
REQ-024 R_EXEC: alu_src_a_o=1, alu_src_b_o=00, alu_op_o=10; -> R_WB. R_WB: reg_write_o=1, reg_dst_o=1, mem_to_reg_o=0; -> FETCH (retire).
REQ-025 I_EXEC: alu_src_a_o=1, alu_src_b_o=10, alu_op_o=00 for 0x08, 11 for 0x0A; -> I_WB. I_WB: reg_write_o=1, reg_dst_o=0; -> FETCH (retire).
REQ-026 BRANCH: alu_src_a_o=1, alu_src_b_o=00, alu_op_o=01, pc_write_cond_o=1, pc_source_o=01; -> FETCH (retire).
REQ-027 JUMP: pc_write_o=1, pc_source_o=10; -> FETCH (retire).
REQ-028 Every output not listed for a state SHALL be 0; all outputs except ir_write_o/pc_write_o in FETCH are Moore.
REQ-029 instr_count_o SHALL increment by 1 on each retire transition, wrap modulo 2^CNT_W; illegal opcodes do not retire.
REQ-030 illegal_o SHALL stay 1 until reset once set.
REQ-031 Cycle counts with mem_ready_i tied 1: R/I-type 4, lw 5, sw 4, beq 3, j 3.

Reset
REQ-032 rst_i=0 SHALL immediately force state INIT, instr_count_o=0, illegal_o=0, all strobes 0, including mid-memory-access.
REQ-033 First FETCH SHALL occur the second rising edge after rst_i deasserts.

Structure
REQ-034 State encoding, opcode constants and alu_op/alu_src_b/pc_source encodings SHALL live in a shared package.
REQ-035 Single module; next-state and output decode as separate always blocks; no sub-module.

Verification
REQ-036 Reset release, mem_ready_i=1, op 0x00 -> INIT, FETCH, DECODE, R_EXEC, R_WB; reg_write_o=1 and reg_dst_o=1 only in R_WB; instr_count_o=1.
REQ-037 op 0x23, mem_ready_i low 3 cycles in MEM_READ -> mem_read_o=1, i_or_d_o=1 held 4 cycles; MEM_WB follows; total 8 cycles.
REQ-038 op 0x04 -> BRANCH with pc_write_cond_o=1, alu_op_o=01, pc_source_o=01, back to FETCH after 3 cycles.
REQ-039 op 0x3F -> DECODE->FETCH, illegal_o=1 sticky, instr_count_o unchanged.
REQ-040 rst_i low in MEM_WRITE -> mem_write_o drops without clock edge, counter=0; CNT_W=4 run 16 retires -> instr_count_o wraps to 0.
